// File: rtl/vm_pkg.sv
// Shared coin codes and output-FSM state encodings for the coin acceptor and vending machine.
package vm_pkg;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        FIVE = 2'b01,
        TEN  = 2'b10
    } coin_code_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EMIT = 2'b01,
        GAP  = 2'b10
    } out_state_e;

endpackage

// File: rtl/coin_acceptor_if.sv
// Sensor/hold inputs and coin outputs of the coin acceptor; master drives sensors, slave is the acceptor.
interface coin_acceptor_if;

    logic       coin5_raw;
    logic       coin10_raw;
    logic       hold;
    logic [1:0] coin_code;
    logic       reject;
    logic       fifo_full;

    modport master (
        output coin5_raw, coin10_raw, hold,
        input  coin_code, reject, fifo_full
    );

    modport slave (
        input  coin5_raw, coin10_raw, hold,
        output coin_code, reject, fifo_full
    );

endinterface

// File: rtl/coin_debounce.sv
// Two-flop synchroniser, counting debouncer and registered rising-edge detector for one coin sensor.
module coin_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic event_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          event_q, event_d;

    // NOTE: defaults first so every path assigns every output -- no latches.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        event_d = level_d & ~level_q;
    end

    // NOTE: state updates use non-blocking assignments so all flops sample together.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            event_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            event_q <= event_d;
        end
    end

    assign event_o = event_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: debounced coin events queued in a FIFO and emitted one per slot to the vending machine.
module coin_acceptor
    import vm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int GAP_CYCLES      = 1
) (
    input  logic            clk,
    input  logic            rst,
    coin_acceptor_if.slave  bus
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic ev5, ev10;

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb5 (
        .clk(clk), .rst(rst), .raw_i(bus.coin5_raw), .event_o(ev5)
    );

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb10 (
        .clk(clk), .rst(rst), .raw_i(bus.coin10_raw), .event_o(ev10)
    );

    coin_code_e    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          fifo_empty, fifo_full;

    out_state_e    state_q, state_d;
    logic [2:0]    gap_q, gap_d;
    coin_code_e    code_q, code_d;
    logic          reject_q, reject_d;
    logic          may_launch, pop, push;
    coin_code_e    push_code;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));

    // The last GAP cycle doubles as the IDLE decision slot, so GAP_CYCLES is the exact 00 spacing between coins.
    assign may_launch = (state_q == IDLE) ||
                        ((state_q == GAP) && (gap_q == 3'(GAP_CYCLES - 1)));
    assign pop        = may_launch && !fifo_empty && !bus.hold;

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        code_d  = NONE;
        case (state_q)
            IDLE: if (pop) state_d = EMIT;
            EMIT: begin
                state_d = GAP;
                gap_d   = '0;
            end
            GAP: begin
                if (may_launch) state_d = pop ? EMIT : IDLE;
                else            gap_d   = gap_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (pop) code_d = mem_q[rd_ptr_q];
    end

    // Simultaneous events on both sensors are ambiguous, so both are returned with one reject.
    always_comb begin
        push      = 1'b0;
        push_code = NONE;
        reject_d  = 1'b0;
        if (ev5 && ev10) begin
            reject_d = 1'b1;
        end else if (ev5 || ev10) begin
            if (fifo_full && !pop) begin
                reject_d = 1'b1;
            end else begin
                push      = 1'b1;
                push_code = ev5 ? FIVE : TEN;
            end
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= IDLE;
            gap_q    <= '0;
            code_q   <= NONE;
            reject_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q  <= count_d;
            state_q  <= state_d;
            gap_q    <= gap_d;
            code_q   <= code_d;
            reject_q <= reject_d;
        end
    end

    // NOTE: queue storage is not reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_code;
    end

    assign bus.coin_code = code_q;
    assign bus.reject    = reject_q;
    assign bus.fifo_full = fifo_full;

endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench for coin_acceptor: expected coins queued at stimulus, popped when coin_code goes nonzero.
module tb_coin_acceptor;
    import vm_pkg::*;

    localparam int DEB   = 4;
    localparam int DEPTH = 4;
    localparam int GAPC  = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    coin_acceptor_if bus();

    coin_acceptor #(
        .DEBOUNCE_CYCLES(DEB),
        .FIFO_DEPTH(DEPTH),
        .GAP_CYCLES(GAPC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    logic [1:0] exp_q[$];
    int         rej_cnt = 0;
    int         last_coin_cyc = -1;
    int         prev_coin_cyc = -1;
    bit         spacing_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: scoreboard pop, coin spacing and reject counting.
    always @(negedge clk) begin
        if (bus.reject) rej_cnt++;
        if (bus.coin_code != 2'b00) begin
            if (exp_q.size() == 0) check("unexpected_coin", int'(bus.coin_code), 0);
            else                   check("coin_order", int'(bus.coin_code), int'(exp_q.pop_front()));
            if (spacing_en && prev_coin_cyc >= 0)
                check("coin_spacing", cyc - prev_coin_cyc, GAPC + 1);
            prev_coin_cyc = cyc;
            last_coin_cyc = cyc;
        end
        if (!spacing_en) prev_coin_cyc = -1;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // which[0] drives the 5 sensor, which[1] the 10 sensor; sensors then rest long enough to debounce low.
    task automatic pulse_coin(input logic [1:0] which, input int hi);
        bus.coin5_raw  = which[0];
        bus.coin10_raw = which[1];
        wait_cycles(hi);
        bus.coin5_raw  = 1'b0;
        bus.coin10_raw = 1'b0;
        wait_cycles(DEB + 4);
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            wait_cycles(1);
            n++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not complete");
    end

    initial begin
        int t0, rej0, saved;

        rst = 1'b1;
        bus.coin5_raw  = 1'b0;
        bus.coin10_raw = 1'b0;
        bus.hold       = 1'b0;
        wait_cycles(3);
        check("rst_coin_code", int'(bus.coin_code), 0);
        check("rst_reject",    int'(bus.reject),    0);
        check("rst_fifo_full", int'(bus.fifo_full), 0);
        rst = 1'b0;
        wait_cycles(2);

        // Single 5 coin: fixed latency from first high sample.
        rej0 = rej_cnt;
        t0   = cyc;
        exp_q.push_back(FIVE);
        pulse_coin(2'b01, 10);
        drain("t1_drain", 20);
        check("t1_latency", last_coin_cyc - t0, DEB + 4);
        check("t1_reject", rej_cnt - rej0, 0);

        // Short glitch is filtered; a long enough pulse is one 10 coin.
        rej0  = rej_cnt;
        saved = last_coin_cyc;
        pulse_coin(2'b10, DEB - 1);
        check("t2_glitch_no_coin", last_coin_cyc, saved);
        check("t2_glitch_reject", rej_cnt - rej0, 0);
        exp_q.push_back(TEN);
        pulse_coin(2'b10, DEB + 2);
        drain("t2_drain", 20);

        // Both sensors at once: one reject, no coin.
        rej0  = rej_cnt;
        saved = last_coin_cyc;
        pulse_coin(2'b11, 8);
        check("t3_reject", rej_cnt - rej0, 1);
        check("t3_no_coin", last_coin_cyc, saved);

        // Hold fills the queue; fifth coin rejected; release gives strict FIFO order with fixed spacing.
        bus.hold = 1'b1;
        rej0 = rej_cnt;
        for (int i = 0; i < 5; i++) begin
            if (i < DEPTH) exp_q.push_back((i % 2 == 1) ? TEN : FIVE);
            pulse_coin((i % 2 == 1) ? 2'b10 : 2'b01, 6);
            if (i == DEPTH - 2) check("t4_not_full_at_3", int'(bus.fifo_full), 0);
            if (i == DEPTH - 1) check("t4_full_at_4", int'(bus.fifo_full), 1);
        end
        check("t4_reject_fifth", rej_cnt - rej0, 1);
        check("t4_still_full", int'(bus.fifo_full), 1);
        spacing_en = 1'b1;
        bus.hold   = 1'b0;
        drain("t4_drain", 40);
        wait_cycles(2);
        spacing_en = 1'b0;
        check("t4_empty_after", int'(bus.fifo_full), 0);

        // Reset with queued coins discards them.
        bus.hold = 1'b1;
        saved    = last_coin_cyc;
        for (int i = 0; i < 3; i++) pulse_coin(2'b01, 6);
        rst = 1'b1;
        wait_cycles(1);
        check("t5_rst_coin_code", int'(bus.coin_code), 0);
        check("t5_rst_fifo_full", int'(bus.fifo_full), 0);
        rst      = 1'b0;
        bus.hold = 1'b0;
        wait_cycles(20);
        check("t5_no_coin_after_rst", last_coin_cyc, saved);

        // Sensor held through a reset mid-debounce is accepted once after a fresh debounce.
        bus.coin10_raw = 1'b1;
        wait_cycles(3);
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        exp_q.push_back(TEN);
        wait_cycles(12);
        bus.coin10_raw = 1'b0;
        wait_cycles(DEB + 4);
        drain("t6_drain", 20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
